// File: rtl/pipelined_mant_normalizer_pkg.sv
// Shared helpers for the mantissa normaliser: shift-amount width derivation and
// the mapping of shift levels onto pipeline stages.
package pipelined_mant_normalizer_pkg;

    function automatic int shift_amt_w(input int width);
        return $clog2(width);
    endfunction

    // Level j (0 = widest shift) lives in stage floor(j*stages/saw).
    function automatic int lvl_stage(input int j, input int stages, input int saw);
        return (j * stages) / saw;
    endfunction

    function automatic bit lvl_is_first(input int j, input int stages, input int saw);
        if (j == 0) return 1'b1;
        return lvl_stage(j - 1, stages, saw) != lvl_stage(j, stages, saw);
    endfunction

    function automatic int stage_last_lvl(input int s, input int stages, input int saw);
        int last;
        last = 0;
        for (int j = 0; j < saw; j++) begin
            if (lvl_stage(j, stages, saw) == s) last = j;
        end
        return last;
    endfunction

endpackage

// File: rtl/pipelined_mant_normalizer_shift_level.sv
// One combinational level of the normaliser: conditionally shifts by 2^K when the
// top 2^K bits are zero and the accumulated shift stays within the exponent limit.
module norm_shift_level
    import pipelined_mant_normalizer_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int EXP_W = 8,
    parameter int SAW   = 5,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0] cur_value,
    input  logic [SAW-1:0]   cur_sa,
    input  logic [EXP_W-1:0] lim,
    output logic [WIDTH-1:0] nxt_value,
    output logic [SAW-1:0]   nxt_sa
);

    localparam int STEP = 1 << K;
    localparam int CW   = ((EXP_W > SAW) ? EXP_W : SAW) + 1;

    logic [CW-1:0] sa_sum;
    logic          take;

    assign sa_sum    = CW'(cur_sa) + CW'(STEP);
    assign take      = (cur_value[WIDTH-1 -: STEP] == '0) && (sa_sum <= CW'(lim));
    assign nxt_value = take ? (cur_value << STEP) : cur_value;
    assign nxt_sa    = take ? SAW'(sa_sum) : cur_sa;

endmodule

// File: rtl/pipelined_mant_normalizer.sv
// Elastic pipelined leading-zero normaliser with exponent-limited shift; the
// shift levels are spread across STAGES register stages.
module pipelined_mant_normalizer
    import pipelined_mant_normalizer_pkg::*;
#(
    parameter int  WIDTH  = 24,
    parameter int  EXP_W  = 8,
    parameter int  STAGES = 2,
    localparam int SAW    = shift_amt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic [SAW-1:0]   out_sa,
    output logic             out_zero,
    output logic             out_denorm
);

    localparam int L = STAGES - 1;

    logic [STAGES-1:0] vld_p, adv;
    logic [STAGES:0]   vchain;

    logic [WIDTH-1:0] val_p  [STAGES];
    logic [SAW-1:0]   sa_p   [STAGES];
    logic [EXP_W-1:0] lim_p  [STAGES];
    logic [EXP_W-1:0] exp_p  [STAGES];
    logic             zero_p [STAGES];

    logic [WIDTH-1:0] src_val  [STAGES];
    logic [SAW-1:0]   src_sa   [STAGES];
    logic [EXP_W-1:0] src_lim  [STAGES];
    logic [EXP_W-1:0] src_exp  [STAGES];
    logic             src_zero [STAGES];
    logic [WIDTH-1:0] nv_val   [STAGES];
    logic [SAW-1:0]   nv_sa    [STAGES];

    function automatic logic [EXP_W-1:0] shift_limit(input logic [EXP_W-1:0] e);
        return (e == '0) ? '0 : e - 1'b1;
    endfunction

    function automatic logic [EXP_W-1:0] norm_exp(input logic [EXP_W-1:0] e,
                                                  input logic [SAW-1:0] sa,
                                                  input logic msb, input logic zero);
        return (zero || !msb) ? '0 : e - EXP_W'(sa);
    endfunction

    always_comb begin
        adv = '0;
        adv[L] = !vld_p[L] || out_ready;
        for (int s = L - 1; s >= 0; s--) adv[s] = !vld_p[s] || adv[s+1];
    end

    assign in_ready  = clrn && adv[0];
    assign vchain    = {vld_p, in_valid};
    assign out_valid = vld_p[L];

    for (genvar s = 0; s < STAGES; s++) begin : g_src
        localparam int LJ = stage_last_lvl(s, STAGES, SAW);
        if (s == 0) begin : g_in
            assign src_val[s]  = in_mant;
            assign src_sa[s]   = '0;
            assign src_lim[s]  = shift_limit(in_exp);
            assign src_exp[s]  = in_exp;
            assign src_zero[s] = (in_mant == '0);
        end else begin : g_reg
            assign src_val[s]  = val_p[s-1];
            assign src_sa[s]   = sa_p[s-1];
            assign src_lim[s]  = lim_p[s-1];
            assign src_exp[s]  = exp_p[s-1];
            assign src_zero[s] = zero_p[s-1];
        end
        assign nv_val[s] = g_lvl[LJ].lvl_value;
        assign nv_sa[s]  = g_lvl[LJ].lvl_sa;
    end

    for (genvar j = 0; j < SAW; j++) begin : g_lvl
        localparam int S = lvl_stage(j, STAGES, SAW);
        logic [WIDTH-1:0] cur_value, lvl_value;
        logic [SAW-1:0]   cur_sa, lvl_sa;
        if (lvl_is_first(j, STAGES, SAW)) begin : g_head
            assign cur_value = src_val[S];
            assign cur_sa    = src_sa[S];
        end else begin : g_chain
            assign cur_value = g_lvl[j-1].lvl_value;
            assign cur_sa    = g_lvl[j-1].lvl_sa;
        end
        norm_shift_level #(.WIDTH(WIDTH), .EXP_W(EXP_W), .SAW(SAW), .K(SAW - 1 - j)) u_lvl (
            .cur_value(cur_value),
            .cur_sa   (cur_sa),
            .lim      (src_lim[S]),
            .nxt_value(lvl_value),
            .nxt_sa   (lvl_sa)
        );
    end

    always_ff @(posedge clk) begin
        if (!clrn) vld_p <= '0;
        else begin
            for (int s = 0; s < STAGES; s++) begin
                if (adv[s]) vld_p[s] <= vchain[s];
            end
        end
    end

    // Stage boundaries 0..STAGES-2: intermediate value, shift so far, limit, exponent, zero flag
    always_ff @(posedge clk) begin
        for (int s = 0; s < STAGES - 1; s++) begin
            if (adv[s] && vchain[s]) begin
                val_p[s]  <= nv_val[s];
                sa_p[s]   <= nv_sa[s];
                lim_p[s]  <= src_lim[s];
                exp_p[s]  <= src_exp[s];
                zero_p[s] <= src_zero[s];
            end
        end
    end

    // Final stage boundary: encoded result registers
    always_ff @(posedge clk) begin
        if (!clrn) begin
            out_mant   <= '0;
            out_exp    <= '0;
            out_sa     <= '0;
            out_zero   <= 1'b0;
            out_denorm <= 1'b0;
        end else if (adv[L] && vchain[L]) begin
            out_mant   <= src_zero[L] ? '0 : nv_val[L];
            out_sa     <= src_zero[L] ? '0 : nv_sa[L];
            out_exp    <= norm_exp(src_exp[L], nv_sa[L], nv_val[L][WIDTH-1], src_zero[L]);
            out_zero   <= src_zero[L];
            out_denorm <= !src_zero[L] && !nv_val[L][WIDTH-1];
        end
    end

endmodule

// File: tb/tb_pipelined_mant_normalizer.sv
// Randomised and directed bench for pipelined_mant_normalizer against a
// leading-zero-count reference model, at STAGES = 2 plus STAGES = 1 and 5.
module tb_pipelined_mant_normalizer;

    typedef struct packed {
        logic [23:0] mant;
        logic [7:0]  e;
        logic [4:0]  sa;
        logic        zero;
        logic        den;
    } res_t;

    int n_cmp  = 0;
    int n_fail = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clrn, in_valid, in_ready, out_valid, out_ready;
    logic [23:0] in_mant, out_mant;
    logic [7:0]  in_exp, out_exp;
    logic [4:0]  out_sa;
    logic        out_zero, out_denorm;

    logic        v_valid;
    logic [23:0] v_mant;
    logic [7:0]  v_exp;
    logic        s1_in_ready, s1_out_valid, s1_zero, s1_den;
    logic [23:0] s1_mant;
    logic [7:0]  s1_exp;
    logic [4:0]  s1_sa;
    logic        s5_in_ready, s5_out_valid, s5_zero, s5_den;
    logic [23:0] s5_mant;
    logic [7:0]  s5_exp;
    logic [4:0]  s5_sa;

    res_t got, got1, got5;
    assign got  = {out_mant, out_exp, out_sa, out_zero, out_denorm};
    assign got1 = {s1_mant, s1_exp, s1_sa, s1_zero, s1_den};
    assign got5 = {s5_mant, s5_exp, s5_sa, s5_zero, s5_den};

    pipelined_mant_normalizer #(.WIDTH(24), .EXP_W(8), .STAGES(2)) dut (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp), .out_sa(out_sa),
        .out_zero(out_zero), .out_denorm(out_denorm)
    );

    pipelined_mant_normalizer #(.WIDTH(24), .EXP_W(8), .STAGES(1)) dut_s1 (
        .clk(clk), .clrn(clrn), .in_valid(v_valid), .in_ready(s1_in_ready),
        .in_mant(v_mant), .in_exp(v_exp), .out_valid(s1_out_valid), .out_ready(1'b1),
        .out_mant(s1_mant), .out_exp(s1_exp), .out_sa(s1_sa),
        .out_zero(s1_zero), .out_denorm(s1_den)
    );

    pipelined_mant_normalizer #(.WIDTH(24), .EXP_W(8), .STAGES(5)) dut_s5 (
        .clk(clk), .clrn(clrn), .in_valid(v_valid), .in_ready(s5_in_ready),
        .in_mant(v_mant), .in_exp(v_exp), .out_valid(s5_out_valid), .out_ready(1'b1),
        .out_mant(s5_mant), .out_exp(s5_exp), .out_sa(s5_sa),
        .out_zero(s5_zero), .out_denorm(s5_den)
    );

    // Reference: count leading zeros, clamp by exponent-1, then encode.
    function automatic res_t model(input logic [23:0] m, input logic [7:0] e);
        int   lz, lim, sa;
        res_t r;
        r  = '0;
        lz = 0;
        while (lz < 24 && m[23-lz] == 1'b0) lz++;
        lim = (e == 0) ? 0 : int'(e) - 1;
        sa  = (lz < lim) ? lz : lim;
        if (m == 0) begin
            r.zero = 1'b1;
            return r;
        end
        r.mant = m << sa;
        r.sa   = sa[4:0];
        if (r.mant[23]) r.e = e - sa[7:0];
        else            r.den = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; v_valid = 1'b0;
        repeat (3) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (got !== res_t'(0)) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", got); end
        n_cmp++; if ({s1_out_valid, s5_out_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_variant_valid: got %b want 00", {s1_out_valid, s5_out_valid}); end
        n_cmp++; if ({got1, got5} !== '0) begin n_fail++; $display("FAIL reset_variant_outputs: got %h %h want 0", got1, got5); end
        clrn = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [23:0] vm [4];
        logic [7:0]  ve [4];
        res_t        want [4];
        int          lat;
        vm = '{24'h800000, 24'h000001, 24'h000100, 24'h000000};
        ve = '{8'h80, 8'h80, 8'h03, 8'h7F};
        want[0] = {24'h800000, 8'h80, 5'd0,  1'b0, 1'b0};
        want[1] = {24'h800000, 8'h69, 5'd23, 1'b0, 1'b0};
        want[2] = {24'h000400, 8'h00, 5'd2,  1'b0, 1'b1};
        want[3] = {24'h000000, 8'h00, 5'd0,  1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_mant = vm[i]; in_exp = ve[i];
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
            n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d want 2", i, lat); end
            n_cmp++; if (got !== want[i]) begin n_fail++; $display("FAIL directed_result[%0d]: got %h want %h", i, got, want[i]); end
            tick();
        end
    endtask

    task automatic test_variants();
        logic [23:0] vm [2];
        logic [7:0]  ve [2];
        res_t        want [2];
        res_t        cap1, cap5;
        int          lat1, lat5;
        vm = '{24'h800000, 24'h000001};
        ve = '{8'h80, 8'h80};
        want[0] = {24'h800000, 8'h80, 5'd0,  1'b0, 1'b0};
        want[1] = {24'h800000, 8'h69, 5'd23, 1'b0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            v_valid = 1'b1; v_mant = vm[i]; v_exp = ve[i];
            tick();
            v_valid = 1'b0;
            lat1 = 0; lat5 = 0; cap1 = '0; cap5 = '0;
            for (int c = 1; c <= 10; c++) begin
                if (lat1 == 0 && s1_out_valid === 1'b1) begin lat1 = c; cap1 = got1; end
                if (lat5 == 0 && s5_out_valid === 1'b1) begin lat5 = c; cap5 = got5; end
                tick();
            end
            n_cmp++; if (lat1 != 1) begin n_fail++; $display("FAIL s1_latency[%0d]: got %0d want 1", i, lat1); end
            n_cmp++; if (cap1 !== want[i]) begin n_fail++; $display("FAIL s1_result[%0d]: got %h want %h", i, cap1, want[i]); end
            n_cmp++; if (lat5 != 5) begin n_fail++; $display("FAIL s5_latency[%0d]: got %0d want 5", i, lat5); end
            n_cmp++; if (cap5 !== want[i]) begin n_fail++; $display("FAIL s5_result[%0d]: got %h want %h", i, cap5, want[i]); end
        end
    endtask

    task automatic test_backpressure();
        res_t        q[$];
        res_t        w;
        logic [23:0] bm [6];
        logic [7:0]  be [6];
        int          sent, got_n;
        sent = 0; got_n = 0;
        for (int i = 0; i < 6; i++) begin
            bm[i] = 24'($urandom) >> $urandom_range(0, 23);
            be[i] = 8'($urandom_range(1, 40));
        end
        for (int c = 0; c < 40 && got_n < 6; c++) begin
            in_valid = (sent < 6);
            if (sent < 6) begin in_mant = bm[sent]; in_exp = be[sent]; end
            out_ready = (c > 2);
            @(negedge clk);
            if (c == 2) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_drop: got %b want 0", in_ready); end
                n_cmp++; if (sent != 2) begin n_fail++; $display("FAIL bp_accepts_before_drop: got %0d want 2", sent); end
            end
            if (in_valid && in_ready) begin q.push_back(model(bm[sent], be[sent])); sent++; end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++; n_fail++; $display("FAIL bp_unexpected_beat: got %h want none", got);
                end else begin
                    w = q.pop_front();
                    n_cmp++; if (got !== w) begin n_fail++; $display("FAIL bp_beat[%0d]: got %h want %h", got_n, got, w); end
                end
                got_n++;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (got_n != 6) begin n_fail++; $display("FAIL bp_beats_out: got %0d want 6", got_n); end
        tick();
    endtask

    task automatic test_random();
        res_t        q[$];
        res_t        w, prev;
        logic        held;
        logic [23:0] m;
        logic [7:0]  e;
        int          drain;
        held = 1'b0; prev = '0;
        for (int c = 0; c < 400; c++) begin
            m = 24'($urandom) >> $urandom_range(0, 24);
            e = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom);
            in_valid = ($urandom_range(0, 9) < 7); in_mant = m; in_exp = e;
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            if (held) begin
                n_cmp++;
                if (out_valid !== 1'b1 || got !== prev) begin
                    n_fail++; $display("FAIL rnd_stall_hold: got %b/%h want 1/%h", out_valid, got, prev);
                end
            end
            if (in_valid && in_ready) q.push_back(model(m, e));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++; n_fail++; $display("FAIL rnd_unexpected_beat: got %h want none", got);
                end else begin
                    w = q.pop_front();
                    n_cmp++; if (got !== w) begin n_fail++; $display("FAIL rnd_beat: got %h want %h", got, w); end
                end
            end
            held = out_valid && !out_ready;
            prev = got;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain = 0;
        while (q.size() != 0 && drain < 20) begin
            @(negedge clk);
            if (out_valid) begin
                w = q.pop_front();
                n_cmp++; if (got !== w) begin n_fail++; $display("FAIL rnd_drain_beat: got %h want %h", got, w); end
            end
            tick();
            drain++;
        end
        n_cmp++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_leftover: got %0d pending want 0", q.size()); end
        tick();
    endtask

    task automatic test_reset_flight();
        int   stale;
        res_t w;
        out_ready = 1'b1;
        in_valid = 1'b1; in_mant = 24'h000001; in_exp = 8'h80;
        tick();
        in_mant = 24'h000100; in_exp = 8'h03;
        tick();
        in_valid = 1'b0;
        clrn = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rf_in_ready_in_reset: got %b want 0", in_ready); end
        tick();
        clrn = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rf_out_valid_after_reset: got %b want 0", out_valid); end
        n_cmp++; if (got !== res_t'(0)) begin n_fail++; $display("FAIL rf_outputs_cleared: got %h want 0", got); end
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
            tick();
        end
        n_cmp++; if (stale != 0) begin n_fail++; $display("FAIL rf_stale_beats: got %0d want 0", stale); end
        in_valid = 1'b1; in_mant = 24'h0000F0; in_exp = 8'h40;
        w = model(24'h0000F0, 8'h40);
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || got !== w) begin n_fail++; $display("FAIL rf_recovery_beat: got %b/%h want 1/%h", out_valid, got, w); end
        tick();
    endtask

    initial begin
        clrn = 1'b0; in_valid = 1'b0; in_mant = '0; in_exp = '0; out_ready = 1'b1;
        v_valid = 1'b0; v_mant = '0; v_exp = '0;
        test_reset();
        test_directed();
        test_variants();
        test_backpressure();
        test_random();
        test_reset_flight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
